// File: rtl/cb_safe_cpu_seq_pkg.sv
// Shared types and mask decode for the safe-CPU run sequencer.
package cb_safe_cpu_seq_pkg;

  typedef enum logic [2:0] {IDLE, RESET_CORES, BOOT, RUN, DONE} seq_state_e;

  localparam logic [1:0] TMR = 2'b00;
  localparam logic [1:0] DMR = 2'b01;

  localparam logic [2:0] MASK_TMR    = 3'b111;
  localparam logic [2:0] MASK_DMR    = 3'b011;
  localparam logic [2:0] MASK_SINGLE = 3'b001;

  // An empty selection would never complete, so fall back to core 0.
  function automatic logic [2:0] decode_mask(input logic [2:0] master,
                                             input logic       safe,
                                             input logic [1:0] cfg);
    logic [2:0] m;
    m = master;
    if (safe && cfg == TMR)      m = MASK_TMR;
    else if (safe && cfg == DMR) m = MASK_DMR;
    if (m == 3'b000) m = MASK_SINGLE;
    return m;
  endfunction

endpackage

// File: rtl/cb_sleep_filter.sv
// Saturating consecutive-cycle counter with freeze; done fires on the last counted cycle.
module cb_sleep_filter #(
  parameter int unsigned TARGET = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  input  logic freeze,
  output logic done
);

  localparam int unsigned     TGT     = (TARGET == 0) ? 1 : TARGET;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TGT - 1);
  localparam bit               ENABLED = (TARGET != 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (freeze)      cnt <= cnt;
    else if (!en)         cnt <= '0;
    else if (cnt != LAST) cnt <= cnt + 1'b1;
  end

  assign done = ENABLED && en && !freeze && !clr && (cnt == LAST);

endmodule

// File: rtl/cb_safe_cpu_sequencer.sv
// Start/EndSw consumer: latches a run config, resets and boots the selected
// cores, then reports completion once they all sit in WFI (or the watchdog fires).
module cb_safe_cpu_sequencer
  import cb_safe_cpu_seq_pkg::*;
#(
  parameter int unsigned NHARTS         = 3,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SLEEP_FILTER   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              Start_i,
  input  logic [2:0]        master_core_i,
  input  logic              safe_mode_i,
  input  logic [1:0]        safe_configuration_i,
  input  logic              critical_section_i,
  input  logic [31:0]       boot_addr_i,
  input  logic [NHARTS-1:0] sleep_i,
  input  logic [NHARTS-1:0] debug_mode_i,
  output logic              EndSw_o,
  output logic [NHARTS-1:0] core_rst_no,
  output logic [NHARTS-1:0] fetch_enable_o,
  output logic [31:0]       core_boot_addr_o,
  output logic [NHARTS-1:0] active_mask_o,
  output logic              critical_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  seq_state_e        state;
  logic              start_q, start_pulse;
  logic [NHARTS-1:0] new_mask;
  logic [CNT_W-1:0]  rcnt;
  logic              in_run, all_sleep, freeze, filt_done, wd_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) start_q <= 1'b0;
    else         start_q <= Start_i;
  end

  assign start_pulse = Start_i & ~start_q;
  assign new_mask    = decode_mask(master_core_i, safe_mode_i, safe_configuration_i);
  assign in_run      = (state == RUN);
  // Unselected cores count as asleep; a selected core in debug stalls the run.
  assign all_sleep   = &(sleep_i | ~active_mask_o);
  assign freeze      = |(debug_mode_i & active_mask_o);

  cb_sleep_filter #(.TARGET(SLEEP_FILTER), .CNT_W(CNT_W)) u_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (!in_run),
    .en     (all_sleep),
    .freeze (freeze),
    .done   (filt_done)
  );

  cb_sleep_filter #(.TARGET(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_watchdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (!in_run),
    .en     (1'b1),
    .freeze (freeze),
    .done   (wd_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      rcnt             <= '0;
      EndSw_o          <= 1'b0;
      core_rst_no      <= '1;
      fetch_enable_o   <= '0;
      core_boot_addr_o <= '0;
      active_mask_o    <= '0;
      critical_o       <= 1'b0;
      busy_o           <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_pulse) begin
            active_mask_o    <= new_mask;
            core_boot_addr_o <= boot_addr_i;
            critical_o       <= critical_section_i;
            core_rst_no      <= ~new_mask;
            rcnt             <= '0;
            EndSw_o          <= 1'b0;
            timeout_o        <= 1'b0;
            busy_o           <= 1'b1;
            state            <= RESET_CORES;
          end
        end
        RESET_CORES: begin
          if (rcnt == RST_LAST) begin
            rcnt           <= '0;
            core_rst_no    <= '1;
            fetch_enable_o <= active_mask_o;
            state          <= BOOT;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        BOOT: state <= RUN;
        RUN: begin
          // Both done strobes are already gated by the debug freeze.
          if (filt_done || wd_done) begin
            EndSw_o        <= 1'b1;
            fetch_enable_o <= '0;
            busy_o         <= 1'b0;
            timeout_o      <= wd_done;
            state          <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_safe_cpu_sequencer.sv
// Randomized bench: predicts each run's completion cycle from the applied sleep/debug trace.
module tb_cb_safe_cpu_sequencer;

  localparam int RST = 4, SF = 8, TO = 50, TL = 256;

  logic        clk = 1'b0, rst_n;
  logic        start, safe, crit;
  logic [2:0]  master, sleep, dbg;
  logic [1:0]  cfg;
  logic [31:0] addr;
  logic        endsw, critq, busy, tmo;
  logic [2:0]  crst, fen, amask;
  logic [31:0] baddr;

  int n_tests = 0, n_fail = 0;
  logic [2:0] slp_tr [TL];
  logic [2:0] dbg_tr [TL];

  always #5 clk = ~clk;

  cb_safe_cpu_sequencer #(
    .NHARTS(3), .RST_CYCLES(RST), .SLEEP_FILTER(SF), .TIMEOUT_CYCLES(TO), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .Start_i(start), .master_core_i(master),
    .safe_mode_i(safe), .safe_configuration_i(cfg), .critical_section_i(crit),
    .boot_addr_i(addr), .sleep_i(sleep), .debug_mode_i(dbg), .EndSw_o(endsw),
    .core_rst_no(crst), .fetch_enable_o(fen), .core_boot_addr_o(baddr),
    .active_mask_o(amask), .critical_o(critq), .busy_o(busy), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_mask(input logic [2:0] m, input logic s, input logic [1:0] c);
    logic [2:0] r;
    if (!s)         r = m;
    else if (c == 0) r = 3'b111;
    else if (c == 1) r = 3'b011;
    else            r = m;
    return (r == 3'b000) ? 3'b001 : r;
  endfunction

  // Index of the last RUN cycle: SF consecutive non-frozen all-asleep cycles,
  // or TO non-frozen cycles in total (timeout wins a tie).
  task automatic predict(input logic [2:0] mk, output int e, output bit to);
    int run, act;
    bit found;
    run = 0; act = 0; found = 0; e = TL - 1; to = 0;
    for (int i = 0; i < TL; i++) begin
      if (!found && (dbg_tr[i] & mk) == 3'b000) begin
        act++;
        run = ((slp_tr[i] | ~mk) == 3'b111) ? run + 1 : 0;
        if (act == TO || run == SF) begin
          e = i; to = (act == TO); found = 1;
        end
      end
    end
  endtask

  task automatic clr_tr();
    for (int i = 0; i < TL; i++) begin slp_tr[i] = 3'b000; dbg_tr[i] = 3'b000; end
  endtask

  task automatic gen_rand();
    int kind, s0, dl, budget;
    kind = $urandom_range(0, 2); s0 = $urandom_range(0, 20); dl = 0; budget = 30;
    for (int i = 0; i < TL; i++) begin
      case (kind)
        0:       slp_tr[i] = (i >= s0 && $urandom_range(0, 9) != 0) ? 3'b111 : 3'($urandom);
        1:       slp_tr[i] = 3'b000;
        default: slp_tr[i] = 3'($urandom);
      endcase
      if (dl == 0 && budget > 0 && $urandom_range(0, 19) == 0) dl = $urandom_range(1, 6);
      if (dl > 0) begin dbg_tr[i] = 3'($urandom_range(1, 7)); dl--; budget--; end
      else dbg_tr[i] = 3'b000;
    end
  endtask

  task automatic do_run(input logic [2:0] m, input logic s, input logic [1:0] c,
                        input logic [31:0] a, input logic cr, input int extra);
    logic [2:0] mk, e_rst, e_fen;
    int e, ridx, last;
    bit to, dph;
    @(negedge clk);
    master = m; safe = s; cfg = c; addr = a; crit = cr; start = 1'b1;
    mk = exp_mask(m, s, c);
    predict(mk, e, to);
    last = RST + 2 + e + extra;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      ridx  = k - RST - 2;
      dph   = (ridx > e);
      e_rst = (k <= RST) ? ~mk : 3'b111;
      e_fen = (k > RST && !dph) ? mk : 3'b000;
      chk("core_rst", crst, e_rst);
      chk("fetch", fen, e_fen);
      chk("endsw", endsw, dph);
      chk("busy", busy, !dph);
      chk("timeout", tmo, dph && to);
      chk("mask", amask, mk);
      chk("boot_addr", baddr, a);
      chk("critical", critq, cr);
      master = 3'($urandom); safe = 1'($urandom); cfg = 2'($urandom);
      addr = $urandom; crit = 1'($urandom);
      start = dph ? 1'b0 : 1'($urandom_range(0, 1));
      if (ridx >= 0 && ridx < TL) begin sleep = slp_tr[ridx]; dbg = dbg_tr[ridx]; end
      else begin sleep = 3'($urandom); dbg = 3'($urandom); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; master = '0; safe = 1'b0; cfg = '0; crit = 1'b0;
    addr = '0; sleep = '0; dbg = '0;
    #22;
    chk("rst_core_rst", crst, 3'b111);
    chk("rst_fetch", fen, 3'b000);
    chk("rst_endsw", endsw, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mask", amask, 3'b000);
    chk("rst_addr", baddr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_endsw", endsw, 1'b0);
    chk("idle_timeout", tmo, 1'b0);

    // single core, sleep arrives on RUN cycle 3
    clr_tr();
    for (int i = 3; i < TL; i++) slp_tr[i] = 3'b010;
    do_run(3'b010, 1'b0, 2'b00, 32'h2000_0000, 1'b0, 3);

    // TMR with a one-cycle sleep glitch
    clr_tr();
    for (int i = 0; i < TL; i++) slp_tr[i] = (i == 5) ? 3'b011 : 3'b111;
    do_run(3'b100, 1'b1, 2'b00, 32'h1000_0040, 1'b1, 2);

    // DMR: core 2 never sleeps but is masked
    clr_tr();
    for (int i = 0; i < TL; i++) slp_tr[i] = 3'b011;
    do_run(3'b100, 1'b1, 2'b01, 32'h0000_0180, 1'b0, 2);

    // watchdog
    clr_tr();
    do_run(3'b001, 1'b0, 2'b10, 32'hdead_0000, 1'b1, 3);

    // debug freeze for 10 cycles mid-filter; also clears the previous timeout
    clr_tr();
    for (int i = 0; i < TL; i++) slp_tr[i] = 3'b111;
    for (int i = 3; i < 13; i++) dbg_tr[i] = 3'b001;
    do_run(3'b001, 1'b1, 2'b00, 32'h0000_8000, 1'b0, 2);

    // zero master selection falls back to core 0
    clr_tr();
    for (int i = 0; i < TL; i++) slp_tr[i] = 3'b001;
    do_run(3'b000, 1'b0, 2'b00, 32'h0000_0004, 1'b0, 1);

    for (int r = 0; r < 12; r++) begin
      gen_rand();
      do_run(3'($urandom), 1'($urandom), 2'($urandom), $urandom, 1'($urandom),
             $urandom_range(1, 4));
    end

    // asynchronous reset while in RUN
    @(negedge clk);
    master = 3'b010; safe = 1'b0; cfg = 2'b00; addr = 32'h4000_0000; crit = 1'b1;
    sleep = 3'b000; dbg = 3'b000; start = 1'b1;
    repeat (RST + 6) @(negedge clk);
    chk("pre_rst_fetch", fen, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_endsw", endsw, 1'b0);
    chk("async_fetch", fen, 3'b000);
    chk("async_core_rst", crst, 3'b111);
    chk("async_busy", busy, 1'b0);
    chk("async_mask", amask, 3'b000);
    chk("async_crit", critq, 1'b0);
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cb_safe_cpu_sequencer.md
Name: cb_safe_cpu_sequencer

Overview:
Consumer end of the Start/EndSw handshake driven by the CB-HEEP control register block. It sits inside the safe CPU wrapper. On a Start request it latches the run configuration (master core, safe mode, DMR/TMR selection, boot address). It then resets and boots the selected cores, waits until every selected core is in WFI, and signals completion on EndSw_o.

Parameters:
NHARTS, 3, number of cores; the mode masks require NHARTS = 3
RST_CYCLES, 4, cycles core reset is held low before boot (>=1)
SLEEP_FILTER, 8, consecutive cycles all selected cores must report sleep before completion (>=1)
TIMEOUT_CYCLES, 0, run-phase watchdog in cycles; 0 disables it
CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, SLEEP_FILTER, TIMEOUT_CYCLES)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
Start_i  in  1  run request (level); the rising edge starts a run
master_core_i  in  3  one-hot master core for non-safe mode
safe_mode_i  in  1  1 = redundant execution
safe_configuration_i  in  2  00 = TMR, 01 = DMR, others = single core
critical_section_i  in  1  latched; forwarded as critical_o
boot_addr_i  in  32  core boot address
sleep_i  in  NHARTS  per-core WFI/sleep status
debug_mode_i  in  NHARTS  per-core debug status
EndSw_o  out  1  software routine finished (level)
core_rst_no  out  NHARTS  per-core reset, active-low
fetch_enable_o  out  NHARTS  per-core fetch enable
core_boot_addr_o  out  32  latched boot address
active_mask_o  out  NHARTS  cores selected for the current run
critical_o  out  1  latched critical section flag
busy_o  out  1  high in RESET_CORES, BOOT and RUN
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - core_rst_no = all 1s (cores are not held in reset).
  - All other outputs = 0; FSM state = IDLE.
- Start edge: start_q is registered each cycle; start_pulse = Start_i & !start_q.
- Mask decode, done at the latch point:
  - safe_mode = 0: mask = master_core_i.
  - safe_mode = 1, config 00: mask = 3'b111.
  - safe_mode = 1, config 01: mask = 3'b011.
  - safe_mode = 1, other config: mask = master_core_i.
  - A mask of zero is replaced by 3'b001.
- FSM:
  - IDLE: on start_pulse, latch the mask, boot_addr_i and critical_section_i; clear the counter; -> RESET_CORES.
  - RESET_CORES: core_rst_no = ~mask; counter counts up; when counter == RST_CYCLES-1, clear the counter and -> BOOT.
  - BOOT: all core resets released; fetch_enable_o = mask; lasts exactly one cycle; -> RUN.
  - RUN: fetch_enable_o stays at mask.
    - all_sleep = &(sleep_i | ~mask).
    - The filter counter increments while all_sleep is high and clears when it is low.
    - When it reaches SLEEP_FILTER-1 with all_sleep still high -> DONE.
    - The watchdog counter is separate and increments every cycle. If TIMEOUT_CYCLES != 0 and it reaches TIMEOUT_CYCLES-1, set timeout_o and -> DONE.
  - DONE: EndSw_o = 1; fetch_enable_o = 0. Hold until start_pulse, then, in the same cycle, clear EndSw_o and timeout_o, latch the new config, and -> RESET_CORES.
- EndSw_o is registered and rises on the cycle after the DONE transition. Minimum Start-to-EndSw latency is 1 + RST_CYCLES + 1 + SLEEP_FILTER cycles.
- Debug freeze: while any (debug_mode_i & mask) bit is set, both RUN counters hold their value and no transition occurs.
- Start_i falling (the control side clears start on the EndSw rising edge) has no effect. start_pulse seen in RESET_CORES/BOOT/RUN is ignored: no abort and no relatch.
- Config inputs changing mid-run are ignored; only the latched copies drive outputs.
- Simultaneous timeout and filter completion in the same cycle: go to DONE with timeout_o = 1.
- Asynchronous reset mid-run: all outputs return to reset values immediately.

Decomposition:
- Package cb_safe_cpu_seq_pkg:
  - state enum: IDLE, RESET_CORES, BOOT, RUN, DONE.
  - safe_configuration localparams: TMR = 2'b00, DMR = 2'b01.
  - Mask constants: 3'b111, 3'b011, 3'b001.
  - Mask-decode function.
- Sub-module cb_sleep_filter: saturating consecutive-cycle counter with enable/freeze and a done output. Instantiated once for the sleep filter; its counter structure is reused for the watchdog.

Test Plan:
1. Single-core boot: safe_mode = 0, master = 3'b010, boot_addr = 0x2000_0000, Start pulse, sleep_i = 3'b010 from cycle 3 after BOOT.
   -> core_rst_no = 3'b101 for 4 cycles; fetch_enable_o = 3'b010; core_boot_addr_o = 0x2000_0000; EndSw_o rises exactly 8 cycles after sleep is asserted.
2. TMR filter glitch: safe_mode = 1, config 00; sleep_i = 3'b111 for 5 cycles, 3'b011 for 1 cycle, then 3'b111 constant.
   -> filter restarts after the glitch; EndSw_o rises 8 cycles after the final rise of 3'b111; active_mask_o = 3'b111.
3. DMR masking: config 01; sleep_i = 3'b011 with core 2 never sleeping.
   -> EndSw_o asserts (core 2 masked); fetch_enable_o[2] = 0 throughout.
4. Watchdog: TIMEOUT_CYCLES = 50, sleep_i = 0.
   -> timeout_o = 1 and EndSw_o = 1 at cycle 50 of RUN; the next Start pulse clears both.
5. Debug freeze: debug_mode_i[0] = 1 for 10 cycles mid-filter.
   -> filter and watchdog counts hold; EndSw_o is delayed by exactly 10 cycles.
6. Robustness:
   - Start pulse during RUN -> ignored.
   - Config changed mid-run -> outputs unchanged.
   - rst_ni asserted in RUN -> EndSw_o = 0, fetch_enable_o = 0, core_rst_no = all 1s immediately.
